// File: rtl/rv_pipe_pkg.sv
// rtl/rv_pipe_pkg.sv - shared RV32I pipeline constants and the IF/ID bundle
package rv_pipe_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0004;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            valid;
    } if_id_t;

    // Fetch addresses are always word aligned; stray low bits are dropped.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - program counter register with redirect/stall next-pc selection
module fetch_pc_gen
    import rv_pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] START_PC = rv_pipe_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] pc
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= START_PC;
        end else if (redirect) begin
            pc <= align_word(redirect_target);
        end else if (!stall) begin
            pc <= pc + XLEN'(4);
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage: pc, IF/ID register and fetch counter
module if_fetch_stage
    import rv_pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = rv_pipe_pkg::RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = rv_pipe_pkg::NOP_INSTR,
    parameter int              CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [XLEN-1:0]  imem_addr,
    input  logic [XLEN-1:0]  imem_rdata,
    input  logic             stall,
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_target,
    output logic [XLEN-1:0]  if_id_pc,
    output logic [XLEN-1:0]  if_id_instr,
    output logic             if_id_valid,
    output logic [CNT_W-1:0] fetch_cnt
);

    logic [XLEN-1:0] pc;
    if_id_t          if_id;

    fetch_pc_gen #(
        .START_PC(RESET_PC)
    ) u_pc_gen (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .pc              (pc)
    );

    // The ROM is combinational, so the pc register addresses it directly.
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_id     <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
            fetch_cnt <= '0;
        end else if (redirect) begin
            // Whatever the ROM returns this cycle is on the wrong path.
            if_id     <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
        end else if (!stall) begin
            if_id     <= '{pc: pc, instr: imem_rdata, valid: 1'b1};
            fetch_cnt <= fetch_cnt + CNT_W'(1);
        end
    end

    assign if_id_pc    = if_id.pc;
    assign if_id_instr = if_id.instr;
    assign if_id_valid = if_id.valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - directed self-checking bench for if_fetch_stage
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [31:0] fetch_cnt;

    logic [31:0] s_imem_addr;
    logic [31:0] s_if_id_pc;
    logic [31:0] s_if_id_instr;
    logic        s_if_id_valid;
    logic [2:0]  s_fetch_cnt;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h04: return 32'h0000_3f37;
            32'h08: return 32'h0040_0093;
            32'h0C: return 32'h01c0_2623;
            32'h10: return 32'h0043_2e83;
            32'h14: return 32'h0050_8113;
            32'h24: return 32'h0000_1c63;
            32'h28: return 32'h0011_0193;
            32'h2C: return 32'h0021_8213;
            32'h30: return 32'h0032_0293;
            32'h34: return 32'h0042_8313;
            default: return 32'h0000_0000;
        endcase
    endfunction

    assign imem_rdata = rom(imem_addr);

    if_fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
        .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
        .fetch_cnt(fetch_cnt)
    );

    if_fetch_stage #(.CNT_W(3)) dut_small (
        .clk(clk), .rst_n(rst_n), .imem_addr(s_imem_addr), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
        .if_id_pc(s_if_id_pc), .if_id_instr(s_if_id_instr), .if_id_valid(s_if_id_valid),
        .fetch_cnt(s_fetch_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic s, input logic [31:0] t);
        redirect = r;
        stall = s;
        redirect_target = t;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        step();
        step();
        tests++; if (imem_addr !== 32'h4) begin failed++; $display("FAIL reset_addr got %h exp %h", imem_addr, 32'h4); end
        tests++; if (if_id_valid !== 1'b0) begin failed++; $display("FAIL reset_valid got %b exp 0", if_id_valid); end
        tests++; if (if_id_instr !== NOP) begin failed++; $display("FAIL reset_instr got %h exp %h", if_id_instr, NOP); end
        tests++; if (if_id_pc !== 32'h0) begin failed++; $display("FAIL reset_pc got %h exp 0", if_id_pc); end
        tests++; if (fetch_cnt !== 32'd0) begin failed++; $display("FAIL reset_cnt got %0d exp 0", fetch_cnt); end
        rst_n = 1'b1;
        step();
        tests++; if (if_id_pc !== 32'h4) begin failed++; $display("FAIL first_pc got %h exp 4", if_id_pc); end
        tests++; if (if_id_instr !== 32'h0000_3f37) begin failed++; $display("FAIL first_instr got %h exp 00003f37", if_id_instr); end
        tests++; if (if_id_valid !== 1'b1) begin failed++; $display("FAIL first_valid got %b exp 1", if_id_valid); end
        tests++; if (imem_addr !== 32'h8) begin failed++; $display("FAIL first_addr got %h exp 8", imem_addr); end
        tests++; if (fetch_cnt !== 32'd1) begin failed++; $display("FAIL first_cnt got %0d exp 1", fetch_cnt); end
    endtask

    task automatic test_stall();
        step();
        step();
        tests++; if (imem_addr !== 32'h10) begin failed++; $display("FAIL pre_stall_addr got %h exp 10", imem_addr); end
        drive(1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            tests++; if (imem_addr !== 32'h10) begin failed++; $display("FAIL stall_addr[%0d] got %h exp 10", i, imem_addr); end
            tests++; if (if_id_pc !== 32'hC) begin failed++; $display("FAIL stall_pc[%0d] got %h exp c", i, if_id_pc); end
            tests++; if (if_id_instr !== 32'h01c0_2623) begin failed++; $display("FAIL stall_instr[%0d] got %h exp 01c02623", i, if_id_instr); end
            tests++; if (fetch_cnt !== 32'd3) begin failed++; $display("FAIL stall_cnt[%0d] got %0d exp 3", i, fetch_cnt); end
        end
        drive(1'b0, 1'b0, 32'h0);
        step();
        tests++; if (if_id_pc !== 32'h10) begin failed++; $display("FAIL release_pc got %h exp 10", if_id_pc); end
        tests++; if (if_id_instr !== 32'h0043_2e83) begin failed++; $display("FAIL release_instr got %h exp 00432e83", if_id_instr); end
        tests++; if (fetch_cnt !== 32'd4) begin failed++; $display("FAIL release_cnt got %0d exp 4", fetch_cnt); end
        tests++; if (imem_addr !== 32'h14) begin failed++; $display("FAIL release_addr got %h exp 14", imem_addr); end
    endtask

    task automatic test_redirect();
        drive(1'b1, 1'b1, 32'hC);
        step();
        tests++; if (imem_addr !== 32'hC) begin failed++; $display("FAIL rs_addr got %h exp c", imem_addr); end
        tests++; if (if_id_valid !== 1'b0) begin failed++; $display("FAIL rs_valid got %b exp 0", if_id_valid); end
        tests++; if (if_id_instr !== NOP) begin failed++; $display("FAIL rs_instr got %h exp %h", if_id_instr, NOP); end
        tests++; if (if_id_pc !== 32'h0) begin failed++; $display("FAIL rs_pc got %h exp 0", if_id_pc); end
        tests++; if (fetch_cnt !== 32'd4) begin failed++; $display("FAIL rs_cnt got %0d exp 4", fetch_cnt); end
        drive(1'b1, 1'b0, 32'h24);
        step();
        tests++; if (imem_addr !== 32'h24) begin failed++; $display("FAIL redir_addr got %h exp 24", imem_addr); end
        tests++; if (if_id_valid !== 1'b0) begin failed++; $display("FAIL redir_valid got %b exp 0", if_id_valid); end
        drive(1'b1, 1'b0, 32'h26);
        step();
        tests++; if (imem_addr !== 32'h24) begin failed++; $display("FAIL misalign_addr got %h exp 24", imem_addr); end
        tests++; if (fetch_cnt !== 32'd4) begin failed++; $display("FAIL b2b_cnt got %0d exp 4", fetch_cnt); end
        drive(1'b0, 1'b0, 32'h0);
        step();
        tests++; if (if_id_pc !== 32'h24) begin failed++; $display("FAIL target_pc got %h exp 24", if_id_pc); end
        tests++; if (if_id_instr !== 32'h0000_1c63) begin failed++; $display("FAIL target_instr got %h exp 00001c63", if_id_instr); end
        tests++; if (if_id_valid !== 1'b1) begin failed++; $display("FAIL target_valid got %b exp 1", if_id_valid); end
        tests++; if (fetch_cnt !== 32'd5) begin failed++; $display("FAIL target_cnt got %0d exp 5", fetch_cnt); end
    endtask

    task automatic test_redirect_after_stall();
        drive(1'b0, 1'b1, 32'h0);
        step();
        tests++; if (if_id_pc !== 32'h24) begin failed++; $display("FAIL ras_hold_pc got %h exp 24", if_id_pc); end
        drive(1'b1, 1'b0, 32'h4);
        step();
        tests++; if (if_id_valid !== 1'b0) begin failed++; $display("FAIL ras_valid got %b exp 0", if_id_valid); end
        tests++; if (if_id_pc !== 32'h0) begin failed++; $display("FAIL ras_pc got %h exp 0", if_id_pc); end
        tests++; if (if_id_instr !== NOP) begin failed++; $display("FAIL ras_instr got %h exp %h", if_id_instr, NOP); end
        tests++; if (imem_addr !== 32'h4) begin failed++; $display("FAIL ras_addr got %h exp 4", imem_addr); end
        tests++; if (fetch_cnt !== 32'd5) begin failed++; $display("FAIL ras_cnt got %0d exp 5", fetch_cnt); end
    endtask

    task automatic test_pc_wrap();
        drive(1'b1, 1'b0, 32'hFFFF_FFFC);
        step();
        tests++; if (imem_addr !== 32'hFFFF_FFFC) begin failed++; $display("FAIL top_addr got %h exp fffffffc", imem_addr); end
        drive(1'b0, 1'b0, 32'h0);
        step();
        tests++; if (imem_addr !== 32'h0) begin failed++; $display("FAIL wrap_addr got %h exp 0", imem_addr); end
        tests++; if (if_id_pc !== 32'hFFFF_FFFC) begin failed++; $display("FAIL wrap_pc got %h exp fffffffc", if_id_pc); end
        tests++; if (if_id_instr !== 32'h0) begin failed++; $display("FAIL zero_instr got %h exp 0", if_id_instr); end
        tests++; if (if_id_valid !== 1'b1) begin failed++; $display("FAIL zero_valid got %b exp 1", if_id_valid); end
        tests++; if (fetch_cnt !== 32'd6) begin failed++; $display("FAIL wrap_cnt got %0d exp 6", fetch_cnt); end
    endtask

    task automatic test_cnt_wrap();
        // Four more loads bring the count to 10, past the 3-bit counter's 7.
        for (int i = 0; i < 4; i++) step();
        tests++; if (fetch_cnt !== 32'd10) begin failed++; $display("FAIL cnt10 got %0d exp 10", fetch_cnt); end
        tests++; if (s_fetch_cnt !== 3'd2) begin failed++; $display("FAIL small_cnt_wrap got %0d exp 2", s_fetch_cnt); end
    endtask

    task automatic test_reset_mid_stream();
        drive(1'b1, 1'b0, 32'h30);
        step();
        tests++; if (imem_addr !== 32'h30) begin failed++; $display("FAIL mid_pre_addr got %h exp 30", imem_addr); end
        drive(1'b0, 1'b0, 32'h0);
        step();
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 32'h8);
        step();
        tests++; if (imem_addr !== 32'h4) begin failed++; $display("FAIL mid_rst_addr got %h exp 4", imem_addr); end
        tests++; if (if_id_valid !== 1'b0) begin failed++; $display("FAIL mid_rst_valid got %b exp 0", if_id_valid); end
        tests++; if (if_id_instr !== NOP) begin failed++; $display("FAIL mid_rst_instr got %h exp %h", if_id_instr, NOP); end
        tests++; if (fetch_cnt !== 32'd0) begin failed++; $display("FAIL mid_rst_cnt got %0d exp 0", fetch_cnt); end
        tests++; if (s_fetch_cnt !== 3'd0) begin failed++; $display("FAIL mid_rst_small_cnt got %0d exp 0", s_fetch_cnt); end
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 32'h0);
        step();
        tests++; if (if_id_pc !== 32'h4) begin failed++; $display("FAIL post_rst_pc got %h exp 4", if_id_pc); end
        tests++; if (fetch_cnt !== 32'd1) begin failed++; $display("FAIL post_rst_cnt got %0d exp 1", fetch_cnt); end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        test_reset();
        test_stall();
        test_redirect();
        test_redirect_after_stall();
        test_pc_wrap();
        test_cnt_wrap();
        test_reset_mid_stream();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
